// File: rtl/disp_seq_pkg.sv
// disp_seq_pkg: shared definitions for display_sequencer.
//   state_e      : sequencer states
//   NDIGITS      : digits per frame
//   encode_din   : (blank, nibble, dot) -> DIN {on, nibble, dp_n}
//   encode_digit : pick digit k out of a packed frame and encode it
package disp_seq_pkg;

  localparam int NDIGITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    DONE
  } state_e;

  // A dark digit is written as all-zero nibble with the dot forced off, so a
  // blanked position always encodes to the same value whatever the data holds.
  function automatic logic [5:0] encode_din(input logic blank, input logic [3:0] nib,
                                            input logic dot);
    return blank ? 6'b000001 : {1'b1, nib, ~dot};
  endfunction

  function automatic logic [5:0] encode_digit(input logic [31:0] data, input logic [7:0] blank,
                                              input logic [7:0] dot, input logic [2:0] k);
    return encode_din(blank[k], data[{k, 2'b00} +: 4], dot[k]);
  endfunction

endpackage

// File: rtl/display_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i : pending requests
//   ptr_i : index of the last owner; search starts at ptr_i+1 (cyclic)
//   gnt_o : one-hot grant
//   idx_o : index of the granted requester
//   vld_o : some request was granted
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      idx_o,
  output logic            vld_o
);

  logic [7:0] req_ext;
  logic [3:0] cand;

  always_comb begin
    req_ext = 8'(req_i);
    vld_o   = 1'b0;
    idx_o   = '0;
    cand    = '0;
    gnt_o   = '0;
    // ptr_i < NREQ, so one conditional subtract wraps the candidate.
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, ptr_i} + 4'(off);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!vld_o && req_ext[cand[2:0]]) begin
        vld_o = 1'b1;
        idx_o = cand[2:0];
      end
    end
    for (int i = 0; i < NREQ; i++) gnt_o[i] = vld_o && (idx_o == 3'(i));
  end

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: shares the 8-digit seven-segment write port between NREQ
// requesters. A granted frame is latched into a shadow copy and replayed
// digit 0..7 as SETUP / STROBE(HOLD) / RELEASE on WADD/DIN/enter; the owner
// gets a one-cycle ack when the frame is done.
//   clk, rst_n            : clock, async active-low reset
//   req[NREQ]             : frame pending per requester
//   frame_data[NREQ*32]   : nibble per digit
//   frame_blank[NREQ*8]   : 1 = digit dark
//   frame_dp[NREQ*8]      : 1 = dot lit
//   ack[NREQ]             : frame-done pulse to the owner
//   busy                  : grant .. DONE
//   grant_id              : current/last owner
//   WADD, DIN, enter      : display write port (all registered)
// Option: DISP_SEQ_SKIP_UNCHANGED_EN keeps a per-digit cache of the last DIN
// written and skips digits whose encoding is unchanged.
module display_sequencer
  import disp_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] frame_data,
  input  logic [NREQ*8-1:0] frame_blank,
  input  logic [NREQ*8-1:0] frame_dp,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [2:0]        WADD,
  output logic [5:0]        DIN,
  output logic              enter
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e          state_q, state_d;
  logic [2:0]      digit_q, digit_d, next_dig;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sh_data_q, sh_data_d;
  logic [7:0]      sh_blank_q, sh_blank_d, sh_dp_q, sh_dp_d;
  logic [2:0]      ptr_q, ptr_d, gid_q, gid_d;
  logic [2:0]      wadd_q, wadd_d;
  logic [5:0]      din_q, din_d;
  logic            enter_q, enter_d, busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NREQ-1:0] arb_gnt;
  logic [2:0]      arb_idx;
  logic            arb_vld;
  logic [31:0]     src_data;
  logic [7:0]      src_blank, src_dp;
  logic            advance, skip_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // One-hot mux of the granted requester's frame.
  always_comb begin
    src_data  = '0;
    src_blank = '0;
    src_dp    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        src_data  = frame_data[i*32 +: 32];
        src_blank = frame_blank[i*8 +: 8];
        src_dp    = frame_dp[i*8 +: 8];
      end
    end
  end

`ifdef DISP_SEQ_SKIP_UNCHANGED_EN
  logic [NDIGITS-1:0][5:0] cache_q, cache_d;
  logic [NDIGITS-1:0]      cvld_q, cvld_d;

  always_comb begin
    cache_d = cache_q;
    cvld_d  = cvld_q;
    if (state_q == RELEASE) begin
      cache_d[wadd_q] = din_q;
      cvld_d[wadd_q]  = 1'b1;
    end
  end

  // din_q already holds encode(digit) while in SETUP.
  assign skip_hit = cvld_q[digit_q] && (cache_q[digit_q] == din_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= '0;
      cvld_q  <= '0;
    end else begin
      cache_q <= cache_d;
      cvld_q  <= cvld_d;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    cnt_d      = cnt_q;
    sh_data_d  = sh_data_q;
    sh_blank_d = sh_blank_q;
    sh_dp_d    = sh_dp_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    wadd_d     = wadd_q;
    din_d      = din_q;
    enter_d    = 1'b0;
    ack_d      = '0;
    advance    = 1'b0;
    next_dig   = digit_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          sh_data_d  = src_data;
          sh_blank_d = src_blank;
          sh_dp_d    = src_dp;
          gid_d      = arb_idx;
          digit_d    = 3'd0;
          wadd_d     = 3'd0;
          // Shadow is loading this edge, so encode straight from the inputs.
          din_d      = encode_digit(src_data, src_blank, src_dp, 3'd0);
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (skip_hit) begin
          advance = 1'b1;
        end else begin
          enter_d = 1'b1;
          cnt_d   = HW'(HOLD - 1);
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          enter_d = 1'b1;
          cnt_d   = cnt_q - HW'(1);
        end
      end
      RELEASE: advance = 1'b1;
      DONE: begin
        ptr_d   = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (digit_q == 3'(NDIGITS - 1)) begin
        state_d = DONE;
        for (int i = 0; i < NREQ; i++) ack_d[i] = (gid_q == 3'(i));
      end else begin
        digit_d = next_dig;
        wadd_d  = next_dig;
        din_d   = encode_digit(sh_data_q, sh_blank_q, sh_dp_q, next_dig);
        state_d = SETUP;
      end
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      digit_q    <= '0;
      cnt_q      <= '0;
      sh_data_q  <= '0;
      sh_blank_q <= '0;
      sh_dp_q    <= '0;
      ptr_q      <= 3'(NREQ - 1);
      gid_q      <= '0;
      wadd_q     <= '0;
      din_q      <= '0;
      enter_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      sh_data_q  <= sh_data_d;
      sh_blank_q <= sh_blank_d;
      sh_dp_q    <= sh_dp_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      wadd_q     <= wadd_d;
      din_q      <= din_d;
      enter_q    <= enter_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign WADD     = wadd_q;
  assign DIN      = din_q;
  assign enter    = enter_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: stimulus pushes expected writes and
// acks into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_display_sequencer;

  localparam int NREQ = 2;
  localparam int HOLD = 4;
`ifdef DISP_SEQ_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*32-1:0]  frame_data = '0;
  logic [NREQ*8-1:0]   frame_blank = '0;
  logic [NREQ*8-1:0]   frame_dp = '0;
  logic [NREQ-1:0]     ack;
  logic                busy;
  logic [2:0]          grant_id;
  logic [2:0]          WADD;
  logic [5:0]          DIN;
  logic                enter;

  display_sequencer #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .frame_data  (frame_data),
    .frame_blank (frame_blank),
    .frame_dp    (frame_dp),
    .ack         (ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .WADD        (WADD),
    .DIN         (DIN),
    .enter       (enter)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] id;
    int         lat;
  } ack_exp_t;

  logic [8:0] exp_w[$];     // {WADD, DIN}
  ack_exp_t   exp_a[$];
  logic [5:0] mcache[8];
  logic [7:0] mvld = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][5:0] enc_frame(input logic [31:0] d, input logic [7:0] b,
                                                input logic [7:0] p);
    logic [7:0][5:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[k] ? 6'b000001 : {1'b1, d[4*k +: 4], ~p[k]};
    return r;
  endfunction

  // Queue the writes a frame should produce, plus its ack and latency.
  task automatic push_frame(input int id, input logic [7:0][5:0] dins);
    int lat = 1;
    for (int k = 0; k < 8; k++) begin
      if (SKIP && mvld[k] && mcache[k] == dins[k]) begin
        lat += 1;
      end else begin
        exp_w.push_back({3'(k), dins[k]});
        mcache[k] = dins[k];
        mvld[k]   = 1'b1;
        lat += HOLD + 2;
      end
    end
    exp_a.push_back('{3'(id), lat});
  endtask

  task automatic set_frame(input int i, input logic [31:0] d, input logic [7:0] b,
                           input logic [7:0] p);
    frame_data[i*32 +: 32] = d;
    frame_blank[i*8 +: 8]  = b;
    frame_dp[i*8 +: 8]     = p;
  endtask

  task automatic wait_acks(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] seen = '0;
    int n = 0;
    while (seen != mask && n < 600) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++) if (ack[i]) begin
        seen[i] = 1'b1;
        req[i]  = 1'b0;
      end
    end
    check("acks_seen", 32'(seen), 32'(mask));
    check("writes_left", exp_w.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor
  logic            en_prev = 1'b0, busy_prev = 1'b0;
  logic [NREQ-1:0] ack_prev = '0;
  int              en_len = 0, grant_cyc = 0;
  logic [8:0]      cur_w = '0, e;
  ack_exp_t        a;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0; busy_prev = 1'b0; ack_prev = '0; en_len = 0;
    end else begin
      if (enter && !en_prev) begin
        if (exp_w.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: WADD=%0d DIN=%b", WADD, DIN);
        end else begin
          e = exp_w.pop_front();
          check("write_wadd", 32'(WADD), 32'(e[8:6]));
          check("write_din", 32'(DIN), 32'(e[5:0]));
        end
        cur_w  = {WADD, DIN};
        en_len = 1;
      end else if (enter) begin
        en_len++;
        check("strobe_stable", 32'({WADD, DIN}), 32'(cur_w));
      end else if (en_prev) begin
        check("enter_width", en_len, HOLD);
        check("release_hold", 32'({WADD, DIN}), 32'(cur_w));
      end
      if (busy && !busy_prev) grant_cyc = cyc;
      if (ack_prev != '0) check("busy_drop", 32'(busy), 0);
      if (ack != '0) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: ack=%b", ack);
        end else begin
          a = exp_a.pop_front();
          check("ack_vec", 32'(ack), 32'd1 << a.id);
          check("ack_gid", 32'(grant_id), 32'(a.id));
          check("ack_latency", cyc - grant_cyc + 1, a.lat);
        end
      end
      en_prev = enter; busy_prev = busy; ack_prev = ack;
    end
  end

  // Hand-computed DIN tables.
  // 0x76543210, blank 0, dp 0x01: {on, k, ~dot}
  logic [7:0][5:0] t_single;
  // 0x76543210, blank 0xF0, dp 0
  logic [7:0][5:0] t_blank;

  initial begin
    int n;
    t_single = {6'b101111, 6'b101101, 6'b101011, 6'b101001,
                6'b100111, 6'b100101, 6'b100011, 6'b100000};
    t_blank  = {6'b000001, 6'b000001, 6'b000001, 6'b000001,
                6'b100111, 6'b100101, 6'b100011, 6'b100001};

    repeat (3) @(negedge clk);
    check("rst_wadd", 32'(WADD), 0);
    check("rst_din", 32'(DIN), 0);
    check("rst_enter", 32'(enter), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gid", 32'(grant_id), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention from reset: requester 0 first, then 1.
    set_frame(0, 32'hFEDCBA98, 8'h00, 8'h00);
    set_frame(1, 32'h01234567, 8'h81, 8'h3C);
    push_frame(0, enc_frame(32'hFEDCBA98, 8'h00, 8'h00));
    push_frame(1, enc_frame(32'h01234567, 8'h81, 8'h3C));
    req = 2'b11;
    wait_acks(2'b11);

    // Single request.
    set_frame(0, 32'h76543210, 8'h00, 8'h01);
    push_frame(0, t_single);
    req = 2'b01;
    wait_acks(2'b01);

    // Blanking.
    set_frame(0, 32'h76543210, 8'hF0, 8'h00);
    push_frame(0, t_blank);
    req = 2'b01;
    wait_acks(2'b01);

    // Reset during digit 3 STROBE.
    set_frame(0, 32'h89ABCDEF, 8'h00, 8'h0F);
    push_frame(0, enc_frame(32'h89ABCDEF, 8'h00, 8'h0F));
    req = 2'b01;
    n = 0;
    while (!(enter && WADD == 3'd3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_d3", 32'({enter, WADD}), 32'({1'b1, 3'd3}));
    #1 rst_n = 1'b0;
    #1;
    check("mrst_enter", 32'(enter), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_wadd", 32'(WADD), 0);
    check("mrst_din", 32'(DIN), 0);
    check("mrst_ack", 32'(ack), 0);
    check("mrst_gid", 32'(grant_id), 0);
    exp_w.delete();
    exp_a.delete();
    mvld = '0;
    req  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset requester 0 wins again.
    set_frame(0, 32'h13579BDF, 8'h01, 8'h80);
    set_frame(1, 32'h2468ACE0, 8'h00, 8'hFF);
    push_frame(0, enc_frame(32'h13579BDF, 8'h01, 8'h80));
    push_frame(1, enc_frame(32'h2468ACE0, 8'h00, 8'hFF));
    req = 2'b11;
    wait_acks(2'b11);

    // req[1] dropped and its frame changed mid-frame: shadow still written.
    set_frame(1, 32'h0F1E2D3C, 8'h00, 8'hA5);
    push_frame(1, enc_frame(32'h0F1E2D3C, 8'h00, 8'hA5));
    req = 2'b10;
    n = 0;
    while (!(enter && WADD == 3'd2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drop_reach_d2", 32'({enter, WADD}), 32'({1'b1, 3'd2}));
    req = 2'b00;
    set_frame(1, 32'hFFFFFFFF, 8'hFF, 8'hFF);
    wait_acks(2'b10);

`ifdef DISP_SEQ_SKIP_UNCHANGED_EN
    // Same frame twice: second has no writes, acks after 8+1 edges.
    set_frame(0, 32'hCAFE1234, 8'h00, 8'h00);
    push_frame(0, enc_frame(32'hCAFE1234, 8'h00, 8'h00));
    req = 2'b01;
    wait_acks(2'b01);
    exp_a.push_back('{3'd0, 9});
    req = 2'b01;
    wait_acks(2'b01);
    // One digit changed: exactly one strobe, digit 5 = 'B' -> {1, 1011, 1}.
    set_frame(0, 32'hCABE1234, 8'h00, 8'h00);
    exp_w.push_back({3'd5, 6'b110111});
    mcache[5] = 6'b110111;
    exp_a.push_back('{3'd0, 9 - 1 + HOLD + 2});
    req = 2'b01;
    wait_acks(2'b01);
`endif

    check("acks_left", exp_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
